// File: rtl/cop_hsk_responder.sv
// Coprocessor-side handshake responder: decodes the instruction in ID and answers
// CHSD/CHSE to the core's interlock. It also sequences the local engine's start/commit and background busy.
module cop_hsk_responder #(
    parameter logic [3:0]  CP_NUM     = 4'd5,
    parameter int unsigned CDP_CYCLES = 3,
    parameter int unsigned LDC_WORDS  = 2,
    parameter int unsigned BG_LATENCY = 4
) (
    input  logic        nGCLK,
    input  logic        nRESET,
    input  logic        nWAIT,
    input  logic [31:0] inst_id,
    input  logic        id_load,
    input  logic        ex_load,
    input  logic        PASS,
    input  logic        LATECANCEL,
    output logic [1:0]  CHSD,
    output logic [1:0]  CHSE,
    output logic        cp_start,
    output logic        cp_commit,
    output logic [3:0]  cp_opcode,
    output logic        cp_busy
);

    localparam logic [1:0] HS_WAIT   = 2'b00;
    localparam logic [1:0] HS_GO     = 2'b01;
    localparam logic [1:0] HS_ABSENT = 2'b10;
    localparam logic [1:0] HS_LAST   = 2'b11;

    localparam logic [3:0] L_CDP_CNT = 4'(CDP_CYCLES);
    localparam logic [3:0] L_LS_CNT  = 4'(LDC_WORDS);
    localparam logic [3:0] L_BG_LAT  = 4'(BG_LATENCY);

    typedef enum logic [1:0] {K_NONE, K_CDP, K_MCR, K_LS} kind_t;
    typedef enum logic [1:0] {S_IDLE, S_EX, S_ME} state_t;

    kind_t      w_dec_kind;
    logic [3:0] w_dec_cnt;
    logic       w_unused_bits;

    kind_t      r_id_kind;
    logic [3:0] r_id_cp;
    logic [3:0] r_id_op;
    logic [3:0] r_id_cnt;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_ex_cnt;
    logic       r_ex_first;
    kind_t      r_ex_kind;
    logic [3:0] r_cp_opcode;
    logic [3:0] r_bg_cnt;

    logic       w_id_match;
    logic [1:0] w_chsd;
    logic       w_can_issue;
    logic       w_launch;

    // Fields the decoder never looks at.
    assign w_unused_bits = ^{inst_id[31:28], inst_id[19:12], inst_id[7:5], inst_id[3:0]};

    always_comb begin
        w_dec_kind = K_NONE;
        w_dec_cnt  = 4'd1;
        if (inst_id[27:24] == 4'b1110) begin
            w_dec_kind = inst_id[4] ? K_MCR : K_CDP;
        end else if (inst_id[27:25] == 3'b110) begin
            w_dec_kind = K_LS;
        end
        case (w_dec_kind)
            K_CDP:   w_dec_cnt = L_CDP_CNT;
            K_LS:    w_dec_cnt = L_LS_CNT;
            default: w_dec_cnt = 4'd1;
        endcase
    end

    assign w_id_match = (r_id_cp == CP_NUM);

    always_comb begin
        w_chsd = HS_GO;
        if (r_id_kind == K_NONE) begin
            w_chsd = HS_LAST;
        end else if (!w_id_match) begin
            w_chsd = HS_ABSENT;
        end else if (r_bg_cnt != 4'd0) begin
            w_chsd = HS_WAIT;
        end else if (r_id_cnt == 4'd1) begin
            w_chsd = HS_LAST;
        end
    end

    assign CHSD        = w_chsd;
    assign w_can_issue = (r_state == S_IDLE) || (r_state == S_ME);
    assign w_launch    = ex_load && w_can_issue && (r_id_kind != K_NONE) &&
                         ((w_chsd == HS_GO) || (w_chsd == HS_LAST));

    // ID slot: a new load replaces it; an accepted advance into EX empties it.
    always_ff @(posedge nGCLK or negedge nRESET) begin
        if (!nRESET) begin
            r_id_kind <= K_NONE;
            r_id_cp   <= 4'd0;
            r_id_op   <= 4'd0;
            r_id_cnt  <= 4'd0;
        end else if (nWAIT) begin
            if (id_load) begin
                r_id_kind <= w_dec_kind;
                r_id_cp   <= inst_id[11:8];
                r_id_op   <= inst_id[23:20];
                r_id_cnt  <= w_dec_cnt;
            end else if (w_launch) begin
                r_id_kind <= K_NONE;
            end
        end
    end

    always_ff @(posedge nGCLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= S_IDLE;
        end else if (nWAIT) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_launch) w_state_next = S_EX;
            end
            S_EX: begin
                if (r_ex_first && !PASS) begin
                    w_state_next = S_IDLE;
                end else if (r_ex_cnt <= 4'd1) begin
                    w_state_next = S_ME;
                end
            end
            S_ME: begin
                w_state_next = w_launch ? S_EX : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Pulses are gated by nWAIT so a frozen cycle never repeats them.
    always_comb begin
        CHSE      = HS_LAST;
        cp_start  = 1'b0;
        cp_commit = 1'b0;
        case (r_state)
            S_EX: begin
                if (r_ex_first && !PASS) begin
                    CHSE = HS_LAST;
                end else begin
                    CHSE = (r_ex_cnt > 4'd1) ? HS_GO : HS_LAST;
                end
                cp_start = r_ex_first && PASS && nWAIT;
            end
            S_ME: begin
                cp_commit = !LATECANCEL && nWAIT;
            end
            default: begin
                CHSE = HS_LAST;
            end
        endcase
    end

    assign cp_busy   = (r_state != S_IDLE) || (r_bg_cnt != 4'd0);
    assign cp_opcode = r_cp_opcode;

    always_ff @(posedge nGCLK or negedge nRESET) begin
        if (!nRESET) begin
            r_ex_cnt    <= 4'd0;
            r_ex_first  <= 1'b0;
            r_ex_kind   <= K_NONE;
            r_cp_opcode <= 4'd0;
        end else if (nWAIT) begin
            if (w_launch) begin
                r_ex_cnt    <= r_id_cnt;
                r_ex_first  <= 1'b1;
                r_ex_kind   <= r_id_kind;
                r_cp_opcode <= r_id_op;
            end else if (r_state == S_EX) begin
                r_ex_first <= 1'b0;
                if (r_ex_cnt != 4'd0) r_ex_cnt <= r_ex_cnt - 4'd1;
            end
        end
    end

    // A committed CDP reload takes priority over the running decrement.
    always_ff @(posedge nGCLK or negedge nRESET) begin
        if (!nRESET) begin
            r_bg_cnt <= 4'd0;
        end else if (nWAIT) begin
            if ((r_state == S_ME) && !LATECANCEL && (r_ex_kind == K_CDP)) begin
                r_bg_cnt <= L_BG_LAT;
            end else if (r_bg_cnt != 4'd0) begin
                r_bg_cnt <= r_bg_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_cop_hsk_responder.sv
// Directed bench for cop_hsk_responder: per-cycle handshake checks plus a start/commit
// scoreboard of expected opcodes consumed when the DUT pulses.
module tb_cop_hsk_responder;

    localparam logic [1:0] WAITC = 2'b00;
    localparam logic [1:0] GO    = 2'b01;
    localparam logic [1:0] ABS   = 2'b10;
    localparam logic [1:0] LAST  = 2'b11;

    logic        nGCLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        nWAIT = 1'b1;
    logic [31:0] inst_id = 32'h0;
    logic        id_load = 1'b0;
    logic        ex_load = 1'b0;
    logic        PASS = 1'b0;
    logic        LATECANCEL = 1'b0;
    logic [1:0]  CHSD;
    logic [1:0]  CHSE;
    logic        cp_start;
    logic        cp_commit;
    logic [3:0]  cp_opcode;
    logic        cp_busy;

    int checks = 0;
    int errors = 0;
    logic [3:0] start_q[$];
    logic [3:0] commit_q[$];

    cop_hsk_responder dut (
        .nGCLK(nGCLK), .nRESET(nRESET), .nWAIT(nWAIT), .inst_id(inst_id),
        .id_load(id_load), .ex_load(ex_load), .PASS(PASS), .LATECANCEL(LATECANCEL),
        .CHSD(CHSD), .CHSE(CHSE), .cp_start(cp_start), .cp_commit(cp_commit),
        .cp_opcode(cp_opcode), .cp_busy(cp_busy)
    );

    always #5 nGCLK = ~nGCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge nGCLK);
        #1;
    endtask

    function automatic logic [31:0] mk_cdp(input logic [3:0] cp, input logic [3:0] op);
        return {4'hE, 4'hE, op, 8'h00, cp, 8'h00};
    endfunction
    function automatic logic [31:0] mk_mcr(input logic [3:0] cp, input logic [3:0] op);
        return {4'hE, 4'hE, op, 8'h00, cp, 8'h10};
    endfunction
    function automatic logic [31:0] mk_ldc(input logic [3:0] cp, input logic [3:0] op);
        return {4'hE, 4'hD, op, 8'h00, cp, 8'h00};
    endfunction

    // Scoreboard: every pulse must match the oldest expected opcode.
    always @(negedge nGCLK) begin
        logic [3:0] e;
        if (cp_start === 1'b1) begin
            if (start_q.size() == 0) begin
                chk("start_unexpected", {31'b0, cp_start}, 32'd0);
            end else begin
                e = start_q.pop_front();
                $display("txn start  opcode=%0h expected=%0h", cp_opcode, e);
                chk("start_opcode", {28'b0, cp_opcode}, {28'b0, e});
            end
        end
        if (cp_commit === 1'b1) begin
            if (commit_q.size() == 0) begin
                chk("commit_unexpected", {31'b0, cp_commit}, 32'd0);
            end else begin
                e = commit_q.pop_front();
                $display("txn commit opcode=%0h expected=%0h", cp_opcode, e);
                chk("commit_opcode", {28'b0, cp_opcode}, {28'b0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // Reset
        repeat (3) @(posedge nGCLK);
        #1;
        chk("rst_chsd", CHSD, LAST);
        chk("rst_chse", CHSE, LAST);
        chk("rst_busy", cp_busy, 0);
        chk("rst_opcode", cp_opcode, 0);
        chk("rst_start", cp_start, 0);
        chk("rst_commit", cp_commit, 0);
        nRESET = 1'b1;
        tick();

        // CDP cp5, PASS=1, commit; busy 3+1+4
        inst_id = mk_cdp(4'd5, 4'hA); id_load = 1'b1; #2;
        chk("t1_chsd_empty", CHSD, LAST);
        tick();
        id_load = 1'b0; ex_load = 1'b1; PASS = 1'b1; #2;
        chk("t1_chsd_go", CHSD, GO);
        start_q.push_back(4'hA); commit_q.push_back(4'hA);
        tick();
        ex_load = 1'b0; #2;
        chk("t1_ex1_chse", CHSE, GO); chk("t1_ex1_busy", cp_busy, 1); chk("t1_ex1_chsd", CHSD, LAST);
        tick(); #2;
        chk("t1_ex2_chse", CHSE, GO);
        tick(); #2;
        chk("t1_ex3_chse", CHSE, LAST);
        tick(); #2;
        chk("t1_me_chse", CHSE, LAST); chk("t1_me_busy", cp_busy, 1);
        tick(); #2;
        chk("t1_bg4_busy", cp_busy, 1);
        tick();
        // Second CDP arrives while background count drains
        inst_id = mk_cdp(4'd5, 4'h3); id_load = 1'b1; #2;
        chk("t1_bg3_busy", cp_busy, 1);
        tick();
        id_load = 1'b0; ex_load = 1'b1; #2;
        chk("t2_wait1", CHSD, WAITC); chk("t1_bg2_busy", cp_busy, 1);
        tick();
        ex_load = 1'b0; #2;
        chk("t2_wait2", CHSD, WAITC); chk("t2_ignored_chse", CHSE, LAST); chk("t1_bg1_busy", cp_busy, 1);
        tick();
        ex_load = 1'b1; PASS = 1'b1; #2;
        chk("t2_go", CHSD, GO); chk("t1_bg0_busy", cp_busy, 0);
        start_q.push_back(4'h3); commit_q.push_back(4'h3);
        tick();
        ex_load = 1'b0; #2;
        chk("t2_ex1_chse", CHSE, GO);
        tick();
        // Stall mid EX
        nWAIT = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("t6_stall_chse", CHSE, GO); chk("t6_stall_busy", cp_busy, 1);
            tick();
        end
        nWAIT = 1'b1; #2;
        chk("t6_ex2_chse", CHSE, GO);
        tick(); #2;
        chk("t6_ex3_chse", CHSE, LAST);
        tick(); #2;
        chk("t6_me_busy", cp_busy, 1);
        tick();
        n = 0;
        while (cp_busy && n < 20) begin n++; tick(); end
        chk("t2_bg_len", n, 4);

        // MCR cp3 -> ABSENT, ex_load ignored
        inst_id = mk_mcr(4'd3, 4'h1); id_load = 1'b1;
        tick();
        id_load = 1'b0; ex_load = 1'b1; PASS = 1'b1; #2;
        chk("t3_chsd_abs", CHSD, ABS);
        tick();
        ex_load = 1'b0; #2;
        chk("t3_chse", CHSE, LAST); chk("t3_busy", cp_busy, 0); chk("t3_chsd_hold", CHSD, ABS);
        tick();

        // LDC cp5, PASS=0
        inst_id = mk_ldc(4'd5, 4'hC); id_load = 1'b1;
        tick();
        id_load = 1'b0; ex_load = 1'b1; PASS = 1'b0; #2;
        chk("t4_chsd_go", CHSD, GO);
        tick();
        ex_load = 1'b0; #2;
        chk("t4_chse_last", CHSE, LAST); chk("t4_ex_busy", cp_busy, 1);
        tick(); #2;
        chk("t4_idle_busy", cp_busy, 0); chk("t4_idle_chse", CHSE, LAST);
        tick();

        // MRC cp5, late cancel
        inst_id = mk_mcr(4'd5, 4'h7); id_load = 1'b1;
        tick();
        id_load = 1'b0; ex_load = 1'b1; PASS = 1'b1; #2;
        chk("t5_chsd_last", CHSD, LAST);
        start_q.push_back(4'h7);
        tick();
        ex_load = 1'b0; #2;
        chk("t5_chse", CHSE, LAST); chk("t5_ex_busy", cp_busy, 1);
        tick();
        LATECANCEL = 1'b1; #2;
        chk("t5_me_busy", cp_busy, 1);
        tick();
        LATECANCEL = 1'b0; #2;
        chk("t5_after_busy", cp_busy, 0);
        tick();

        // id_load with ex_load, then issue from ME
        inst_id = mk_cdp(4'd5, 4'h9); id_load = 1'b1;
        tick();
        inst_id = mk_mcr(4'd5, 4'h2); ex_load = 1'b1; PASS = 1'b1; #2;
        chk("t7_chsd_go", CHSD, GO);
        start_q.push_back(4'h9); commit_q.push_back(4'h9);
        tick();
        id_load = 1'b0; ex_load = 1'b0; #2;
        chk("t7_ex1_chse", CHSE, GO); chk("t7_new_slot", CHSD, LAST);
        tick(); #2;
        chk("t7_ex2_chse", CHSE, GO);
        tick(); #2;
        chk("t7_ex3_chse", CHSE, LAST);
        tick();
        ex_load = 1'b1; #2;
        chk("t7_me_chsd", CHSD, LAST);
        start_q.push_back(4'h2); commit_q.push_back(4'h2);
        tick();
        ex_load = 1'b0; #2;
        chk("t7_mrc_chse", CHSE, LAST); chk("t7_mrc_busy", cp_busy, 1); chk("t7_mrc_op", cp_opcode, 4'h2);
        tick(); #2;
        chk("t7_me2_busy", cp_busy, 1);
        tick();
        n = 0;
        while (cp_busy && n < 20) begin n++; tick(); end
        chk("t7_drain", cp_busy, 0);

        // Reset mid-op
        inst_id = mk_cdp(4'd5, 4'h4); id_load = 1'b1;
        tick();
        id_load = 1'b0; ex_load = 1'b1; PASS = 1'b1;
        start_q.push_back(4'h4);
        tick();
        ex_load = 1'b0;
        tick();
        nRESET = 1'b0; #1;
        chk("t8_rst_chse", CHSE, LAST); chk("t8_rst_busy", cp_busy, 0);
        chk("t8_rst_op", cp_opcode, 0); chk("t8_rst_chsd", CHSD, LAST);
        tick(); tick();
        nRESET = 1'b1;
        tick(); #2;
        chk("t8_post_chse", CHSE, LAST); chk("t8_post_busy", cp_busy, 0);
        tick();

        chk("start_q_empty", start_q.size(), 0);
        chk("commit_q_empty", commit_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
